// File: rtl/game_pkg.sv
// Shared constants and state encoding for the obstacle game.
// Box sizes here must match the ones the VGA renderer draws.
package game_pkg;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;
  localparam logic [9:0] OBS_W    = 10'd30;
  localparam logic [9:0] OBS_H    = 10'd30;
  localparam logic [9:0] PLAYER_W = 10'd30;
  localparam logic [9:0] PLAYER_H = 10'd30;
  localparam logic [9:0] PLAYER_Y = 10'd315;
  localparam logic [9:0] SPEED    = 10'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_HIT     = 2'b10
  } state_t;

  // Fold an LFSR value into 0..max_x-1 with one subtract;
  // valid because the LFSR never exceeds 2*max_x-1.
  function automatic logic [9:0] spawn_x(
    input logic [9:0]  l,
    input logic [10:0] max_x
  );
    logic [10:0] le;
    le = {1'b0, l};
    if (le >= max_x) begin
      spawn_x = 10'(le - max_x);
    end else begin
      spawn_x = l;
    end
  endfunction

endpackage

// File: rtl/obstacle_game_ctrl_if.sv
// Control/status bundle between the game logic and its users.
// master drives the controls; slave is the game controller.
interface obstacle_game_ctrl_if;

  logic       frame_tick;
  logic       start;
  logic [9:0] player_x;
  logic [9:0] obstacle_x;
  logic [9:0] obstacle_y;
  logic [9:0] obstacle_width;
  logic [9:0] obstacle_height;
  logic [1:0] game_state;
  logic       hit;
  logic [7:0] score;

  modport master (
    output frame_tick, start, player_x,
    input  obstacle_x, obstacle_y,
    input  obstacle_width, obstacle_height,
    input  game_state, hit, score
  );

  modport slave (
    input  frame_tick, start, player_x,
    output obstacle_x, obstacle_y,
    output obstacle_width, obstacle_height,
    output game_state, hit, score
  );

endinterface

// File: rtl/obstacle_game_ctrl_lfsr.sv
// 10-bit Fibonacci LFSR, x^10 + x^7 + 1, maximal length.
// Seeded non-zero on reset so it can never lock up.
module lfsr10 (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] q
);

  // Shift left every cycle, feedback from taps 10 and 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 10'h001;
    end else begin
      q <= {q[8:0], q[9] ^ q[6]};
    end
  end

endmodule

// File: rtl/obstacle_game_ctrl.sv
// Falling-obstacle game logic: spawn, per-frame motion,
// player collision and the IDLE/RUNNING/HIT state machine.
module obstacle_game_ctrl
  import game_pkg::*;
#(
  parameter logic [9:0] P_SCREEN_W = SCREEN_W,
  parameter logic [9:0] P_SCREEN_H = SCREEN_H,
  parameter logic [9:0] P_OBS_W    = OBS_W,
  parameter logic [9:0] P_OBS_H    = OBS_H,
  parameter logic [9:0] P_PLAYER_W = PLAYER_W,
  parameter logic [9:0] P_PLAYER_H = PLAYER_H,
  parameter logic [9:0] P_PLAYER_Y = PLAYER_Y,
  parameter logic [9:0] P_SPEED    = SPEED
) (
  input logic                 clk,
  input logic                 rst,
  obstacle_game_ctrl_if.slave g
);

  localparam logic [10:0] MAX_X =
    {1'b0, P_SCREEN_W} - {1'b0, P_OBS_W} + 11'd1;

  logic [9:0]  lfsr_q;
  state_t      st;
  logic [9:0]  ox;
  logic [9:0]  oy;
  logic [7:0]  sc;
  logic        hit_q;

  logic [10:0] ox_e;
  logic [10:0] oy_e;
  logic [10:0] px_e;
  logic [10:0] ny;
  logic        coll;
  logic        wrap;
  logic [9:0]  new_x;

  lfsr10 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign ox_e  = {1'b0, ox};
  assign oy_e  = {1'b0, oy};
  assign px_e  = {1'b0, g.player_x};
  assign ny    = oy_e + {1'b0, P_SPEED};
  assign wrap  = ny >= {1'b0, P_SCREEN_H};
  assign new_x = spawn_x(lfsr_q, MAX_X);

  // Boxes overlap when they intersect on both axes.
  assign coll =
    (ox_e < px_e + {1'b0, P_PLAYER_W}) &&
    (px_e < ox_e + {1'b0, P_OBS_W}) &&
    (oy_e < {1'b0, P_PLAYER_Y} + {1'b0, P_PLAYER_H}) &&
    ({1'b0, P_PLAYER_Y} < oy_e + {1'b0, P_OBS_H});

  // Game FSM; start beats any tick in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_IDLE;
      ox    <= 10'd0;
      oy    <= P_SCREEN_H;
      sc    <= 8'd0;
      hit_q <= 1'b0;
    end else if (g.start) begin
      st    <= ST_RUNNING;
      ox    <= new_x;
      oy    <= 10'd0;
      sc    <= 8'd0;
      hit_q <= 1'b0;
    end else begin
      unique case (st)
        ST_RUNNING: begin
          if (g.frame_tick) begin
            if (coll) begin
              st    <= ST_HIT;
              hit_q <= 1'b1;
            end else if (wrap) begin
              ox <= new_x;
              oy <= 10'd0;
              if (sc != 8'hFF) begin
                sc <= sc + 8'd1;
              end
            end else begin
              oy <= ny[9:0];
            end
          end
        end
        ST_IDLE, ST_HIT: begin
        end
        default: begin
          st    <= ST_IDLE;
          hit_q <= 1'b0;
        end
      endcase
    end
  end

  assign g.obstacle_x      = ox;
  assign g.obstacle_y      = oy;
  assign g.obstacle_width  = P_OBS_W;
  assign g.obstacle_height = P_OBS_H;
  assign g.game_state      = st;
  assign g.hit             = hit_q;
  assign g.score           = sc;

endmodule

// File: tb/tb_obstacle_game_ctrl.sv
// Directed bench for obstacle_game_ctrl with a reference model
// feeding a scoreboard queue of expected outputs.
module tb_obstacle_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  obstacle_game_ctrl_if g ();

  obstacle_game_ctrl dut (
    .clk (clk),
    .rst (rst),
    .g   (g)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] sc;
    logic       hit;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  int m_st = 0;
  int m_x = 0;
  int m_y = 480;
  int m_sc = 0;
  int m_l = 1;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int spawn(input int l);
    return (l >= 611) ? l - 611 : l;
  endfunction

  task automatic model_step(
    input logic t,
    input logic s,
    input logic r
  );
    int  px;
    int  ny;
    bit  c;
    px = int'(g.player_x);
    if (r) begin
      m_st = 0;
      m_x = 0;
      m_y = 480;
      m_sc = 0;
      m_l = 1;
      return;
    end
    if (s) begin
      m_st = 1;
      m_y = 0;
      m_x = spawn(m_l);
      m_sc = 0;
    end else if (m_st == 1 && t) begin
      c = (m_x < px + 30) && (px < m_x + 30) &&
          (m_y < 345) && (315 < m_y + 30);
      if (c) begin
        m_st = 2;
      end else begin
        ny = m_y + 4;
        if (ny >= 480) begin
          m_y = 0;
          m_x = spawn(m_l);
          if (m_sc < 255) m_sc = m_sc + 1;
        end else begin
          m_y = ny;
        end
      end
    end
    m_l = ((m_l << 1) & 'h3FF) |
          (((m_l >> 9) ^ (m_l >> 6)) & 1);
  endtask

  task automatic cyc(
    input logic t,
    input logic s,
    input logic r,
    input bit   chk
  );
    exp_t e;
    g.frame_tick = t;
    g.start = s;
    rst = r;
    model_step(t, s, r);
    if (chk) begin
      e.st  = 2'(m_st);
      e.x   = 10'(m_x);
      e.y   = 10'(m_y);
      e.sc  = 8'(m_sc);
      e.hit = (m_st == 2);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    g.frame_tick = 1'b0;
    g.start = 1'b0;
    rst = 1'b0;
    if (chk) begin
      e = q.pop_front();
      check("sb_state", 32'(g.game_state), 32'(e.st));
      check("sb_x", 32'(g.obstacle_x), 32'(e.x));
      check("sb_y", 32'(g.obstacle_y), 32'(e.y));
      check("sb_score", 32'(g.score), 32'(e.sc));
      check("sb_hit", 32'(g.hit), 32'(e.hit));
    end
  endtask

  task automatic far();
    g.player_x = (m_x < 300) ? 10'd600 : 10'd0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      far();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_l(input int v);
    for (int i = 0; i < 1100; i++) begin
      if (m_l == v) break;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("lfsr_reach", 32'(m_l), 32'(v));
  endtask

  initial begin
    g.frame_tick = 1'b0;
    g.start = 1'b0;
    g.player_x = 10'd600;

    // reset
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_state", 32'(g.game_state), 32'd0);
    check("rst_y", 32'(g.obstacle_y), 32'd480);
    check("rst_x", 32'(g.obstacle_x), 32'd0);
    check("rst_score", 32'(g.score), 32'd0);
    check("rst_hit", 32'(g.hit), 32'd0);
    check("width", 32'(g.obstacle_width), 32'd30);
    check("height", 32'(g.obstacle_height), 32'd30);

    // idle ignores ticks
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("idle_tick_y", 32'(g.obstacle_y), 32'd480);

    // start with L=700 -> x=89
    wait_l(700);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("st700_state", 32'(g.game_state), 32'd1);
    check("st700_y", 32'(g.obstacle_y), 32'd0);
    check("st700_x", 32'(g.obstacle_x), 32'd89);
    check("st700_score", 32'(g.score), 32'd0);

    ticks(3);
    check("move3_y", 32'(g.obstacle_y), 32'd12);

    // no tick -> hold
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // restart with L=300 -> x=300
    wait_l(300);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("st300_x", 32'(g.obstacle_x), 32'd300);

    // descend to 476 then wrap
    for (int i = 0; i < 130; i++) begin
      if (m_y == 476) break;
      far();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("pre_wrap_y", 32'(g.obstacle_y), 32'd476);
    far();
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("wrap_y", 32'(g.obstacle_y), 32'd0);
    check("wrap_score", 32'(g.score), 32'd1);

    // start + tick together at y=200
    ticks(50);
    check("y200", 32'(g.obstacle_y), 32'd200);
    far();
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("st_tick_y", 32'(g.obstacle_y), 32'd0);
    check("st_tick_score", 32'(g.score), 32'd0);
    check("st_tick_state", 32'(g.game_state), 32'd1);

    // collision at x=90, y=300, player 100
    wait_l(90);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("st90_x", 32'(g.obstacle_x), 32'd90);
    ticks(75);
    check("y300", 32'(g.obstacle_y), 32'd300);
    g.player_x = 10'd100;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("hit_state", 32'(g.game_state), 32'd2);
    check("hit_flag", 32'(g.hit), 32'd1);
    check("hit_y", 32'(g.obstacle_y), 32'd300);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("hit_hold_y", 32'(g.obstacle_y), 32'd300);
    check("hit_hold_st", 32'(g.game_state), 32'd2);

    // touching edge x=130 is not a hit
    wait_l(130);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("st130_x", 32'(g.obstacle_x), 32'd130);
    ticks(75);
    g.player_x = 10'd100;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("edge_state", 32'(g.game_state), 32'd1);
    check("edge_y", 32'(g.obstacle_y), 32'd304);
    check("edge_hit", 32'(g.hit), 32'd0);

    // score saturation
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40000; i++) begin
      if (m_sc == 255) break;
      far();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_score", 32'(g.score), 32'd255);
    for (int i = 0; i < 130; i++) begin
      far();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (m_y == 0) break;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_wrap_y", 32'(g.obstacle_y), 32'd0);
    check("sat_keep", 32'(g.score), 32'd255);

    // mid-game reset with a coincident tick
    ticks(5);
    far();
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("mrst_state", 32'(g.game_state), 32'd0);
    check("mrst_y", 32'(g.obstacle_y), 32'd480);
    check("mrst_x", 32'(g.obstacle_x), 32'd0);
    check("mrst_score", 32'(g.score), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("resume_state", 32'(g.game_state), 32'd1);
    check("resume_y", 32'(g.obstacle_y), 32'd0);
    ticks(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("resume_move", 32'(g.obstacle_y), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
